cic_comb_m256_n1: RTL and testbench

CIC_COMB_M256_N1 -- requirements
Module: cic_comb_m256_n1

---
 rtl/cic_comb_m256_n1_pkg.sv | 17 +
 rtl/cic_comb_m256_n1_if.sv | 24 ++
 rtl/cic_comb_delay_ram.sv | 24 ++
 rtl/cic_comb_m256_n1.sv | 95 +++++++++
 tb/tb_cic_comb_m256_n1.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cic_comb_m256_n1_pkg.sv
// Shared channelizer CIC constants: comb geometry and DSP48 integrator opcodes.
// Integrator, comb and downstream decimation stages all take their sizes from here.
package cic_comb_m256_n1_pkg;

  localparam int CIC_IW     = 5;
  localparam int CIC_M      = 256;
  localparam int CIC_LOG2_M = $clog2(CIC_M);
  localparam int CIC_SIG_W  = CIC_IW + CIC_LOG2_M;
  localparam int CIC_IN_W   = 48;

  // Upstream DSP48 opcode; the comb sees opcode 1 as its clear strobe
  typedef enum logic [0:0] {
    DSP_OP_ACCUM = 1'b0,
    DSP_OP_CLEAR = 1'b1
  } dsp_op_e;

endpackage

// File: rtl/cic_comb_m256_n1_if.sv
// Sample stream between the DSP48 integrator and the CIC comb stage.
interface cic_comb_m256_n1_if #(
  parameter int IN_W  = 48,
  parameter int SIG_W = 13
);

  logic [IN_W-1:0]  p_in;
  logic             in_valid;
  logic             clear;
  logic [SIG_W-1:0] out_data;
  logic             out_valid;
  logic             primed;

  modport master (
    output p_in, in_valid, clear,
    input  out_data, out_valid, primed
  );

  modport slave (
    input  p_in, in_valid, clear,
    output out_data, out_valid, primed
  );

endinterface

// File: rtl/cic_comb_delay_ram.sv
// Simple dual-port M x SIG_W delay line with registered read-first output.
module cic_comb_delay_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on purpose: contents are only trusted once the fill counter says so
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cic_comb_m256_n1.sv
// CIC comb, N=1: y[n] = x[n] - x[n-M] on the low SIG_W bits of the integrator word.
// Two-cycle latency: RAM read, subtract, register.
module cic_comb_m256_n1
  import cic_comb_m256_n1_pkg::*;
#(
  parameter int IW    = CIC_IW,
  parameter int M     = CIC_M,
  parameter int IN_W  = CIC_IN_W,
  parameter int SIG_W = IW + $clog2(M)
) (
  input  logic                clk,
  input  logic                resetn,
  cic_comb_m256_n1_if.slave   bus
);

  localparam int AW = $clog2(M);
  localparam logic [AW:0] FILL_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next, wr_addr;
  logic [AW:0]      fill_reg, fill_next;
  logic             restart, accept, use_sub;
  logic [SIG_W-1:0] x, ram_rdata, diff;
  logic [SIG_W-1:0] x_d1_reg;
  logic             v1_reg, use_sub_d1_reg;
  logic [SIG_W-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             unused_p_in_hi;

  // Modular CIC arithmetic lets the integrator's upper bits be dropped
  assign x              = bus.p_in[SIG_W-1:0];
  assign unused_p_in_hi = ^bus.p_in[IN_W-1:SIG_W];

  always_comb begin
    restart     = (dsp_op_e'(bus.clear) == DSP_OP_CLEAR);
    accept      = bus.in_valid;
    wr_addr     = restart ? '0 : wr_ptr_reg;
    use_sub     = !restart && (fill_reg == FILL_FULL);
    wr_ptr_next = wr_ptr_reg;
    fill_next   = fill_reg;
    if (restart) begin
      wr_ptr_next = '0;
      fill_next   = '0;
    end
    // A sample arriving with clear becomes the first post-clear sample
    if (accept) begin
      wr_ptr_next = wr_addr + 1'b1;
      if (fill_next != FILL_FULL) begin
        fill_next = fill_next + 1'b1;
      end
    end
  end

  cic_comb_delay_ram #(
    .DEPTH (M),
    .WIDTH (SIG_W)
  ) u_delay_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (x),
    .raddr (wr_addr),
    .rdata (ram_rdata)
  );

  assign diff = x_d1_reg - (use_sub_d1_reg ? ram_rdata : '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg     <= '0;
      fill_reg       <= '0;
      v1_reg         <= 1'b0;
      x_d1_reg       <= '0;
      use_sub_d1_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      fill_reg      <= fill_next;
      v1_reg        <= accept;
      out_valid_reg <= v1_reg;
      if (accept) begin
        x_d1_reg       <= x;
        use_sub_d1_reg <= use_sub;
      end
      if (v1_reg) begin
        out_data_reg <= diff;
      end
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.primed    = (fill_reg == FILL_FULL);

endmodule

// File: tb/tb_cic_comb_m256_n1.sv
// Directed bench for the M=256 CIC comb: reset, step, wrap, clear, bursty valid, mid-stream reset.
module tb_cic_comb_m256_n1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic        ev [0:1999];
  logic [12:0] ed [0:1999];

  always #5 clk = ~clk;

  cic_comb_m256_n1_if #(.IN_W(48), .SIG_W(13)) bus ();

  cic_comb_m256_n1 dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always @(negedge clk) begin
    if (resetn && bus.out_valid) $display("[%0t] out_data=%0d primed=%b", $time, bus.out_data, bus.primed);
  end

  task automatic cyc(input logic v, input logic [47:0] p, input logic c, input logic rn);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.p_in     = p;
    bus.clear    = c;
    resetn       = rn;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b0, 48'd0, 1'b0, 1'b0);
    cyc(1'b0, 48'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cyc(1'b1, 48'd5, 1'b0, 1'b0);
      else       cyc(1'b0, 48'd0, 1'b0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 13'd0 || bus.primed !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got valid=%b data=%0d primed=%b, want 0/0/0", i, bus.out_valid, bus.out_data, bus.primed);
      end
    end
  endtask

  task automatic test_step();
    logic [12:0] last = '0;
    logic ev_now;
    do_reset();
    for (int i = 0; i < 304; i++) begin
      cyc(i < 300, 48'(i + 1), 1'b0, 1'b1);
      ev[i] = (i < 300);
      ed[i] = (i + 1 <= 256) ? 13'(i + 1) : 13'd256;
      ev_now = (i >= 2) && ev[i-2];
      if (ev_now) last = ed[i-2];
      n_checks++;
      if (bus.out_valid !== ev_now || bus.out_data !== last) begin
        n_fail++;
        $display("FAIL step[%0d]: got valid=%b data=%0d, want valid=%b data=%0d", i, bus.out_valid, bus.out_data, ev_now, last);
      end
      n_checks++;
      if (bus.primed !== (i >= 256)) begin
        n_fail++;
        $display("FAIL step_primed[%0d]: got %b, want %b", i, bus.primed, (i >= 256));
      end
    end
  endtask

  task automatic test_wrap();
    logic [12:0] last = '0;
    logic [47:0] p;
    logic ev_now;
    do_reset();
    for (int i = 0; i < 604; i++) begin
      p = 48'd0 - 48'd300 + 48'(i);
      cyc(i < 600, p, 1'b0, 1'b1);
      ev[i] = (i < 600);
      ed[i] = (i < 256) ? p[12:0] : 13'd256;
      ev_now = (i >= 2) && ev[i-2];
      if (ev_now) last = ed[i-2];
      n_checks++;
      if (bus.out_valid !== ev_now || bus.out_data !== last) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got valid=%b data=%0d, want valid=%b data=%0d", i, bus.out_valid, bus.out_data, ev_now, last);
      end
    end
  endtask

  task automatic test_clear_collision();
    logic [12:0] last = '0;
    logic ev_now, ep;
    int s, a;
    do_reset();
    for (int i = 0; i < 1304; i++) begin
      s = i + 1;
      cyc(i < 1300, 48'(s), (s == 1000), 1'b1);
      ev[i] = (i < 1300);
      if (s <= 256)       ed[i] = 13'(s);
      else if (s < 1000)  ed[i] = 13'd256;
      else if (s < 1256)  ed[i] = 13'(s);
      else                ed[i] = 13'd256;
      ev_now = (i >= 2) && ev[i-2];
      if (ev_now) last = ed[i-2];
      a  = (i < 1300) ? i : 1300;
      ep = (a >= 256 && a < 1000) || (a >= 1255);
      n_checks++;
      if (bus.out_valid !== ev_now || bus.out_data !== last) begin
        n_fail++;
        $display("FAIL clear[%0d]: got valid=%b data=%0d, want valid=%b data=%0d", i, bus.out_valid, bus.out_data, ev_now, last);
      end
      n_checks++;
      if (bus.primed !== ep) begin
        n_fail++;
        $display("FAIL clear_primed[%0d]: got %b, want %b", i, bus.primed, ep);
      end
    end
  endtask

  task automatic test_clear_idle();
    logic [12:0] last = '0;
    logic [47:0] pv [0:4] = '{48'd10, 48'd20, 48'd30, 48'd0, 48'd40};
    logic        vv [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        cv [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic ev_now;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) cyc(vv[i], pv[i], cv[i], 1'b1);
      else       cyc(1'b0, 48'd0, 1'b0, 1'b1);
      ev[i] = (i < 5) ? vv[i] : 1'b0;
      ed[i] = (i < 5) ? pv[i][12:0] : 13'd0;
      ev_now = (i >= 2) && ev[i-2];
      if (ev_now) last = ed[i-2];
      n_checks++;
      if (bus.out_valid !== ev_now || bus.out_data !== last) begin
        n_fail++;
        $display("FAIL clear_idle[%0d]: got valid=%b data=%0d, want valid=%b data=%0d", i, bus.out_valid, bus.out_data, ev_now, last);
      end
    end
  endtask

  task automatic test_bursty();
    logic [12:0] last = '0;
    logic ev_now, v;
    int k = 0;
    int k_prev;
    int n_in = 0;
    int n_out = 0;
    do_reset();
    for (int i = 0; i < 1604; i++) begin
      k_prev = k;
      v = (i < 1600) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v) begin
        k++;
        n_in++;
        cyc(1'b1, 48'(3 * k), 1'b0, 1'b1);
      end else begin
        cyc(1'b0, {$urandom, $urandom_range(0, 65535)}, 1'b0, 1'b1);
      end
      ev[i] = v;
      ed[i] = (k <= 256) ? 13'(3 * k) : 13'd768;
      ev_now = (i >= 2) && ev[i-2];
      if (ev_now) last = ed[i-2];
      if (bus.out_valid === 1'b1) n_out++;
      n_checks++;
      if (bus.out_valid !== ev_now || bus.out_data !== last) begin
        n_fail++;
        $display("FAIL bursty[%0d]: got valid=%b data=%0d, want valid=%b data=%0d", i, bus.out_valid, bus.out_data, ev_now, last);
      end
      n_checks++;
      if (bus.primed !== (k_prev >= 256)) begin
        n_fail++;
        $display("FAIL bursty_primed[%0d]: got %b, want %b", i, bus.primed, (k_prev >= 256));
      end
    end
    n_checks++;
    if (n_out !== n_in) begin
      n_fail++;
      $display("FAIL bursty_count: got %0d out_valid pulses, want %0d", n_out, n_in);
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] last = '0;
    logic [47:0] p;
    logic ev_now;
    int s;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      s = i + 1;
      p = 48'(700 * s);
      if (i < 60) cyc(1'b1, p, 1'b0, (s != 50));
      else        cyc(1'b0, 48'd0, 1'b0, 1'b1);
      ev[i] = (i < 60) && (s < 49 || s > 50);
      ed[i] = p[12:0];
      ev_now = (i >= 2) && ev[i-2];
      if (i == 50) last = '0;
      if (ev_now) last = ed[i-2];
      n_checks++;
      if (bus.out_valid !== ev_now || bus.out_data !== last || bus.primed !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got valid=%b data=%0d primed=%b, want valid=%b data=%0d primed=0", i, bus.out_valid, bus.out_data, bus.primed, ev_now, last);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.p_in     = 48'd5;
    bus.clear    = 1'b0;
    test_reset();
    test_step();
    test_wrap();
    test_clear_collision();
    test_clear_idle();
    test_bursty();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
